// File: rtl/llc_pipe_pkg.sv
// Shared constants for the LLC pipeline head arbiter: requester indices,
// default class mask, starvation limit and the grant-rule encoding.
package llc_pipe_pkg;

   localparam int LLC_SRC_RSP = 0;
   localparam int LLC_SRC_REQ = 1;
   localparam int LLC_SRC_FWD = 2;
   localparam int LLC_SRC_DMA = 3;

   localparam int LLC_NUM_REQ_DEFAULT = LLC_SRC_DMA + 1;
   localparam logic [LLC_NUM_REQ_DEFAULT-1:0] LLC_HI_PRIO_MASK_DEFAULT = 4'b0001;
   localparam int LLC_STARVE_LIMIT_DEFAULT = 8;

   // Which arbitration rule produced this cycle's grant; only RR moves the pointer.
   typedef enum logic [2:0] {
      GR_NONE,
      GR_LOCK,
      GR_STARVE,
      GR_PRIO,
      GR_RR
   } llc_grant_rule_e;

   function automatic int llcIdxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/llc_rr_picker.sv
// Combinational rotating-priority encoder: picks the first set request
// strictly after the pointer, wrapping modulo NUM_REQ.
module llc_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   logic [IDX_W-1:0] candIdx;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      candIdx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         candIdx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         if (!any_o && req_i[candIdx]) begin
            any_o            = 1'b1;
            idx_o            = candIdx;
            grant_o[candIdx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/llc_pipe_arbiter.sv
// N-input arbiter feeding a one-entry valid/ready output register at the
// head of the LLC pipeline, with lock, fixed-priority, starvation and RR rules.
module llc_pipe_arbiter
   import llc_pipe_pkg::*;
#(
   parameter int                 NUM_REQ      = LLC_NUM_REQ_DEFAULT,
   parameter int                 DATA_WIDTH   = 64,
   parameter type                dtype        = logic [DATA_WIDTH-1:0],
   parameter logic [NUM_REQ-1:0] HI_PRIO_MASK = NUM_REQ'(LLC_HI_PRIO_MASK_DEFAULT),
   parameter int                 STARVE_LIMIT = LLC_STARVE_LIMIT_DEFAULT,
   localparam int                IDX_W        = llcIdxWidth(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_valid_in,
   input  dtype               req_data_in [NUM_REQ],
   input  logic [NUM_REQ-1:0] req_lock_in,
   output logic [NUM_REQ-1:0] req_ready_out,
   input  logic               pipe_ready_in,
   output logic               pipe_valid_out,
   output dtype               pipe_data_out,
   output logic [IDX_W-1:0]   pipe_src_out,
   output logic               locked_out
);

   localparam int                 CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [NUM_REQ-1:0] LO_MASK = ~HI_PRIO_MASK;
   localparam bit                 LOCK_EN = (NUM_REQ > 1);

   logic             pipeValid_q, pipeValid_d;
   dtype             pipeData_q, pipeData_d;
   logic [IDX_W-1:0] pipeSrc_q, pipeSrc_d;
   logic             locked_q, locked_d;
   logic [IDX_W-1:0] lockOwner_q, lockOwner_d;
   logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
   logic [CNT_W-1:0] cnt_q [NUM_REQ];
   logic [CNT_W-1:0] cnt_d [NUM_REQ];

   logic               canLoad;
   logic               xfer;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grantIdx;
   llc_grant_rule_e    grantRule;

   logic               starveAny, hiAny;
   logic [IDX_W-1:0]   starveIdx, hiIdx;
   logic [NUM_REQ-1:0] rrGrant;
   logic [IDX_W-1:0]   rrIdx;
   logic               rrAny;

   assign canLoad = !pipeValid_q || pipe_ready_in;

   llc_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_picker (
      .req_i   (req_valid_in & LO_MASK),
      .ptr_i   (rrPtr_q),
      .grant_o (rrGrant),
      .idx_o   (rrIdx),
      .any_o   (rrAny)
   );

   // Lowest-index search for starving low-class and high-class requesters.
   always_comb begin
      starveAny = 1'b0;
      starveIdx = '0;
      hiAny     = 1'b0;
      hiIdx     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (LO_MASK[i] && req_valid_in[i] && cnt_q[i] == CNT_W'(STARVE_LIMIT)) begin
            starveAny = 1'b1;
            starveIdx = IDX_W'(i);
         end
         if (HI_PRIO_MASK[i] && req_valid_in[i]) begin
            hiAny = 1'b1;
            hiIdx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      grant     = '0;
      grantIdx  = '0;
      grantRule = GR_NONE;
      if (LOCK_EN && locked_q) begin
         if (req_valid_in[lockOwner_q]) begin
            grant[lockOwner_q] = 1'b1;
            grantIdx           = lockOwner_q;
            grantRule          = GR_LOCK;
         end
      end else if (starveAny) begin
         grant[starveIdx] = 1'b1;
         grantIdx         = starveIdx;
         grantRule        = GR_STARVE;
      end else if (hiAny) begin
         grant[hiIdx] = 1'b1;
         grantIdx     = hiIdx;
         grantRule    = GR_PRIO;
      end else if (rrAny) begin
         grant     = rrGrant;
         grantIdx  = rrIdx;
         grantRule = GR_RR;
      end
   end

   assign req_ready_out = canLoad ? grant : '0;
   assign xfer          = |req_ready_out;

   // Output register, lock, pointer and starvation counters advance together.
   always_comb begin
      pipeValid_d = pipeValid_q;
      pipeData_d  = pipeData_q;
      pipeSrc_d   = pipeSrc_q;
      locked_d    = locked_q;
      lockOwner_d = lockOwner_q;
      rrPtr_d     = rrPtr_q;
      if (xfer) begin
         pipeValid_d = 1'b1;
         pipeData_d  = req_data_in[grantIdx];
         pipeSrc_d   = grantIdx;
         if (LOCK_EN && req_lock_in[grantIdx]) begin
            locked_d    = 1'b1;
            lockOwner_d = grantIdx;
         end else begin
            locked_d = 1'b0;
         end
         if (grantRule == GR_RR) begin
            rrPtr_d = grantIdx;
         end
      end else if (pipe_ready_in) begin
         pipeValid_d = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         cnt_d[i] = '0;
         if (LO_MASK[i] && req_valid_in[i] && !(xfer && grant[i])) begin
            cnt_d[i] = (cnt_q[i] == CNT_W'(STARVE_LIMIT)) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipeValid_q <= 1'b0;
         pipeData_q  <= '0;
         pipeSrc_q   <= '0;
         locked_q    <= 1'b0;
         lockOwner_q <= '0;
         rrPtr_q     <= IDX_W'(NUM_REQ - 1);
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         pipeValid_q <= pipeValid_d;
         pipeData_q  <= pipeData_d;
         pipeSrc_q   <= pipeSrc_d;
         locked_q    <= locked_d;
         lockOwner_q <= lockOwner_d;
         rrPtr_q     <= rrPtr_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign pipe_valid_out = pipeValid_q;
   assign pipe_data_out  = pipeData_q;
   assign pipe_src_out   = pipeSrc_q;
   assign locked_out     = locked_q;

endmodule

// File: tb/tb_llc_pipe_arbiter.sv
// Randomized scoreboard bench for llc_pipe_arbiter against a rule-level
// reference model of grant selection, locking and starvation.
module tb_llc_pipe_arbiter;

   localparam int         N     = 4;
   localparam int         LIMIT = 8;
   localparam logic [3:0] HI    = 4'b0001;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  reqValid;
   logic [N-1:0]  reqLock;
   logic [N-1:0]  reqReady;
   logic [63:0]   reqData [N];
   logic          pipeReady;
   logic          pipeValid;
   logic [63:0]   pipeData;
   logic [1:0]    pipeSrc;
   logic          locked;

   llc_pipe_arbiter #(
      .NUM_REQ      (N),
      .DATA_WIDTH   (64),
      .HI_PRIO_MASK (HI),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_in   (reqValid),
      .req_data_in    (reqData),
      .req_lock_in    (reqLock),
      .req_ready_out  (reqReady),
      .pipe_ready_in  (pipeReady),
      .pipe_valid_out (pipeValid),
      .pipe_data_out  (pipeData),
      .pipe_src_out   (pipeSrc),
      .locked_out     (locked)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  src;
      logic [63:0] data;
   } beat_t;

   beat_t expQ[$];
   int    checks = 0;
   int    errors = 0;

   bit    mLocked;
   int    mOwner;
   int    mPtr;
   int    mCnt [N];
   bit    mOutValid;
   int    burstLeft [N];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mLocked   = 1'b0;
      mOwner    = 0;
      mPtr      = N - 1;
      mOutValid = 1'b0;
      for (int i = 0; i < N; i++) mCnt[i] = 0;
   endtask

   // Decides this cycle's winner from the arbitration rules, checks the DUT's
   // visible state, and advances the model as of the coming clock edge.
   task automatic modelStep(output int taken);
      int       g;
      int       j;
      bit       viaRr;
      bit       canLoad;
      bit       xfer;
      logic [3:0] expReady;
      beat_t    e;
      g       = -1;
      viaRr   = 1'b0;
      canLoad = !mOutValid || pipeReady;
      if (mLocked) begin
         if (reqValid[mOwner]) g = mOwner;
      end else begin
         for (int i = 0; i < N; i++)
            if (g < 0 && !HI[i] && reqValid[i] && mCnt[i] == LIMIT) g = i;
         for (int i = 0; i < N; i++)
            if (g < 0 && HI[i] && reqValid[i]) g = i;
         for (int k = 1; k <= N; k++) begin
            j = (mPtr + k) % N;
            if (g < 0 && !HI[j] && reqValid[j]) begin
               g     = j;
               viaRr = 1'b1;
            end
         end
      end
      xfer     = (g >= 0) && canLoad;
      expReady = xfer ? (4'b0001 << g) : 4'b0000;
      checkOutput("req_ready", 64'(reqReady), 64'(expReady));
      checkOutput("locked", 64'(locked), 64'(mLocked));
      checkOutput("pipe_valid", 64'(pipeValid), 64'(mOutValid));
      if (xfer) begin
         e.src  = 2'(g);
         e.data = reqData[g];
         expQ.push_back(e);
      end
      for (int i = 0; i < N; i++) begin
         if (HI[i] || !reqValid[i] || (xfer && g == i)) mCnt[i] = 0;
         else if (mCnt[i] < LIMIT) mCnt[i] = mCnt[i] + 1;
      end
      if (xfer) begin
         if (reqLock[g]) begin
            mLocked = 1'b1;
            mOwner  = g;
         end else begin
            mLocked = 1'b0;
         end
         if (viaRr) mPtr = g;
         mOutValid = 1'b1;
      end else if (pipeReady) begin
         mOutValid = 1'b0;
      end
      taken = xfer ? g : -1;
   endtask

   function automatic bit wantValid(input int i, input int cyc);
      int phase;
      phase = (cyc / 800) % 4;
      case (phase)
         0:       return $urandom_range(99) < 50;
         1:       return (i == 0) ? 1'b1 : ($urandom_range(99) < 70);
         2:       return $urandom_range(99) < 85;
         default: return $urandom_range(99) < 30;
      endcase
   endfunction

   // Requesters keep valid/data/lock stable until accepted; bursts hold lock
   // on every beat but the last.
   task automatic applyStimulus(input int cyc, input int taken);
      for (int i = 0; i < N; i++) begin
         if (i == taken) begin
            burstLeft[i] = burstLeft[i] - 1;
            if (burstLeft[i] > 0) begin
               reqData[i] = {$urandom, $urandom};
               reqLock[i] = (burstLeft[i] > 1);
               continue;
            end
            reqValid[i] = 1'b0;
            reqLock[i]  = 1'b0;
         end else if (reqValid[i]) begin
            continue;
         end
         if (wantValid(i, cyc)) begin
            burstLeft[i] = ($urandom_range(3) == 0) ? int'($urandom_range(4, 2)) : 1;
            reqValid[i]  = 1'b1;
            reqData[i]   = {$urandom, $urandom};
            reqLock[i]   = (burstLeft[i] > 1);
         end else begin
            reqValid[i] = 1'b0;
            reqLock[i]  = 1'b0;
         end
      end
      if (((cyc / 800) % 4) == 2) pipeReady = ($urandom_range(99) < 50);
      else                        pipeReady = ($urandom_range(99) < 80);
   endtask

   // Scoreboard monitor: every beat drained downstream must match the queue head.
   always @(negedge clk) begin
      beat_t e;
      if (!rst && pipeValid && pipeReady) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_beat", 64'(pipeSrc), 64'hFFFF);
         end else begin
            e = expQ.pop_front();
            checkOutput("beat_src", 64'(pipeSrc), 64'(e.src));
            checkOutput("beat_data", pipeData, e.data);
         end
      end
   end

   initial begin
      int taken;
      int nextReset;
      reqValid  = '0;
      reqLock   = '0;
      pipeReady = 1'b0;
      for (int i = 0; i < N; i++) begin
         reqData[i]   = '0;
         burstLeft[i] = 0;
      end
      modelReset();
      taken     = -1;
      nextReset = 1300;

      #12;
      checkOutput("reset_pipe_valid", 64'(pipeValid), 64'd0);
      checkOutput("reset_pipe_data", pipeData, 64'd0);
      checkOutput("reset_pipe_src", 64'(pipeSrc), 64'd0);
      checkOutput("reset_locked", 64'(locked), 64'd0);
      checkOutput("reset_req_ready", 64'(reqReady), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int cyc = 0; cyc < 3200; cyc++) begin
         applyStimulus(cyc, taken);
         if (cyc >= nextReset && pipeValid) begin
            rst = 1'b1;
            #1;
            checkOutput("async_reset_valid", 64'(pipeValid), 64'd0);
            checkOutput("async_reset_locked", 64'(locked), 64'd0);
            checkOutput("async_reset_data", pipeData, 64'd0);
            modelReset();
            expQ.delete();
            #1 rst = 1'b0;
            nextReset = nextReset + 900;
         end
         @(negedge clk);
         modelStep(taken);
         @(posedge clk);
         #1;
      end

      reqValid  = '0;
      reqLock   = '0;
      pipeReady = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         modelStep(taken);
         @(posedge clk);
         #1;
      end
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
